// File: rtl/mem_port_arbiter_if.sv
// +------------------------------------------------------------------------+
// | mem_port_arbiter_if : I-side, D-side and memory bus bundle             |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  // Arbiter side
  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
    input  mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output mem_read, mem_write, mem_address, mem_wdata
  );

  // Requester / memory side
  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
    output mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +------------------------------------------------------------------------+
// | mem_port_arbiter : round-robin I/D arbiter for one line memory port    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
  localparam logic [LINE_WIDTH-1:0] LINE_ZERO = '0;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       last_grant;
  logic       last_grant_next;
  logic       i_req;
  logic       d_req;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        // On a tie the side that was not granted last wins.
        if (i_req && (!d_req || last_grant == GRANT_D)) begin
          state_next      = SERVE_I;
          last_grant_next = GRANT_I;
        end else if (d_req) begin
          state_next      = SERVE_D;
          last_grant_next = GRANT_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.mem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // Strobes come only from the registered state; requests never reach memory directly.
  always_comb begin
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = ADDR_ZERO;
    bus.mem_wdata   = LINE_ZERO;
    bus.i_resp      = 1'b0;
    bus.d_resp      = 1'b0;
    case (state)
      SERVE_I: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = bus.i_address;
        bus.i_resp      = bus.mem_resp;
      end
      SERVE_D: begin
        // An illegal read+write collapses to a write.
        bus.mem_read    = bus.d_read & ~bus.d_write;
        bus.mem_write   = bus.d_write;
        bus.mem_address = bus.d_address;
        bus.mem_wdata   = bus.d_wdata;
        bus.d_resp      = bus.mem_resp;
      end
      default: ;
    endcase
  end

  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +------------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed self-checking bench for mem_port_arbiter|
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  localparam logic [255:0] DATA_A = {64{4'hA}};
  localparam logic [255:0] DATA_W = {8{32'h1234_5678}};
  localparam logic [255:0] DATA_5 = {64{4'h5}};

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.i_read    = 1'b0;
    bus.i_address = '0;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_address = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_resp  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    settle();

    // Reset state, with a stray mem_resp in IDLE
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = DATA_5;
    bus.d_wdata   = DATA_W;
    settle();
    check("rst_mem_read",  256'(bus.mem_read),    256'(0));
    check("rst_mem_write", 256'(bus.mem_write),   256'(0));
    check("rst_mem_addr",  256'(bus.mem_address), 256'(0));
    check("rst_mem_wdata", bus.mem_wdata,         256'(0));
    check("idle_i_resp",   256'(bus.i_resp),      256'(0));
    check("idle_d_resp",   256'(bus.d_resp),      256'(0));
    tick();
    bus.mem_resp = 1'b0;
    bus.d_wdata  = '0;
    settle();
    check("idle_stays", 256'(bus.mem_read | bus.mem_write), 256'(0));

    // Single I read, memory answers on the third strobe cycle
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_0040;
    settle();
    check("i1_no_comb_path", 256'(bus.mem_read), 256'(0));
    tick();
    settle();
    check("i1_mem_read", 256'(bus.mem_read),    256'(1));
    check("i1_mem_addr", 256'(bus.mem_address), 256'(32'h40));
    check("i1_d_resp",   256'(bus.d_resp),      256'(0));
    check("i1_i_resp_early", 256'(bus.i_resp),  256'(0));
    tick();
    settle();
    check("i1_hold", 256'(bus.mem_read), 256'(1));
    tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = DATA_A;
    settle();
    check("i1_i_resp",  256'(bus.i_resp), 256'(1));
    check("i1_i_rdata", bus.i_rdata,      DATA_A);
    check("i1_d_resp2", 256'(bus.d_resp), 256'(0));
    tick();
    bus.i_read   = 1'b0;
    bus.mem_resp = 1'b0;
    settle();
    check("i1_idle", 256'(bus.mem_read), 256'(0));
    check("i1_resp_gone", 256'(bus.i_resp), 256'(0));

    // Single D write
    bus.d_write   = 1'b1;
    bus.d_address = 32'h0000_1000;
    bus.d_wdata   = DATA_W;
    tick();
    settle();
    check("dw_mem_write", 256'(bus.mem_write),   256'(1));
    check("dw_mem_read",  256'(bus.mem_read),    256'(0));
    check("dw_mem_addr",  256'(bus.mem_address), 256'(32'h1000));
    check("dw_mem_wdata", bus.mem_wdata,         DATA_W);
    tick();
    settle();
    check("dw_hold", 256'(bus.mem_write), 256'(1));
    bus.mem_resp = 1'b1;
    settle();
    check("dw_d_resp", 256'(bus.d_resp), 256'(1));
    check("dw_i_resp", 256'(bus.i_resp), 256'(0));
    tick();
    bus.d_write  = 1'b0;
    bus.mem_resp = 1'b0;
    settle();
    check("dw_idle", 256'(bus.mem_write), 256'(0));
    check("dw_resp_once", 256'(bus.d_resp), 256'(0));

    // Simultaneous requests straight out of reset: I first
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_read    = 1'b1;
    bus.d_read    = 1'b1;
    bus.i_address = 32'h0000_0080;
    bus.d_address = 32'h0000_2000;
    tick();
    settle();
    check("sim_first_addr", 256'(bus.mem_address), 256'(32'h80));
    bus.mem_resp = 1'b1;
    settle();
    check("sim_i_resp", 256'(bus.i_resp), 256'(1));
    check("sim_d_resp0", 256'(bus.d_resp), 256'(0));
    tick();
    bus.i_read   = 1'b0;
    bus.mem_resp = 1'b0;
    settle();
    check("sim_bubble", 256'(bus.mem_read), 256'(0));
    tick();
    settle();
    check("sim_second_addr", 256'(bus.mem_address), 256'(32'h2000));
    check("sim_second_read", 256'(bus.mem_read),    256'(1));
    bus.mem_resp = 1'b1;
    settle();
    check("sim_d_resp", 256'(bus.d_resp), 256'(1));
    tick();
    bus.d_read   = 1'b0;
    bus.mem_resp = 1'b0;
    settle();
    check("sim_done", 256'(bus.mem_read), 256'(0));

    // Continuous contention: grants alternate I, D, I, D, I, D
    bus.i_read    = 1'b1;
    bus.d_read    = 1'b1;
    bus.i_address = 32'h0000_0100;
    bus.d_address = 32'h0000_3000;
    for (int k = 0; k < 6; k++) begin
      tick();
      settle();
      check($sformatf("cont%0d_addr", k), 256'(bus.mem_address),
            (k % 2 == 0) ? 256'(32'h100) : 256'(32'h3000));
      bus.mem_resp = 1'b1;
      settle();
      check($sformatf("cont%0d_i_resp", k), 256'(bus.i_resp), 256'(k % 2 == 0));
      check($sformatf("cont%0d_d_resp", k), 256'(bus.d_resp), 256'(k % 2 == 1));
      tick();
      bus.mem_resp = 1'b0;
      settle();
      check($sformatf("cont%0d_bubble", k), 256'(bus.mem_read), 256'(0));
    end
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;

    // D request queued behind an in-flight I read
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_0300;
    tick();
    bus.d_read    = 1'b1;
    bus.d_address = 32'h0000_4000;
    settle();
    check("q_i_addr", 256'(bus.mem_address), 256'(32'h300));
    tick();
    settle();
    check("q_i_addr_hold", 256'(bus.mem_address), 256'(32'h300));
    check("q_d_resp0",     256'(bus.d_resp),      256'(0));
    bus.mem_resp = 1'b1;
    settle();
    check("q_i_resp", 256'(bus.i_resp), 256'(1));
    tick();
    bus.i_read   = 1'b0;
    bus.mem_resp = 1'b0;
    settle();
    check("q_bubble", 256'(bus.mem_read), 256'(0));
    tick();
    settle();
    check("q_d_addr", 256'(bus.mem_address), 256'(32'h4000));
    check("q_d_read", 256'(bus.mem_read),    256'(1));
    bus.mem_resp = 1'b1;
    settle();
    check("q_d_resp", 256'(bus.d_resp), 256'(1));
    tick();
    bus.d_read   = 1'b0;
    bus.mem_resp = 1'b0;

    // Reset in the second SERVE_D cycle, late mem_resp ignored
    bus.d_write   = 1'b1;
    bus.d_address = 32'h0000_5000;
    tick();
    tick();
    rst = 1'b1;
    settle();
    check("rm_write_before", 256'(bus.mem_write), 256'(1));
    tick();
    rst          = 1'b0;
    bus.d_write  = 1'b0;
    bus.mem_resp = 1'b1;
    settle();
    check("rm_write_off", 256'(bus.mem_write), 256'(0));
    check("rm_read_off",  256'(bus.mem_read),  256'(0));
    check("rm_no_d_resp", 256'(bus.d_resp),    256'(0));
    tick();
    bus.mem_resp  = 1'b0;
    bus.i_read    = 1'b1;
    bus.d_read    = 1'b1;
    bus.i_address = 32'h0000_0500;
    bus.d_address = 32'h0000_6000;
    tick();
    settle();
    check("rm_tie_to_i", 256'(bus.mem_address), 256'(32'h500));
    check("rm_tie_read", 256'(bus.mem_read),    256'(1));
    bus.mem_resp = 1'b1;
    settle();
    check("rm_i_resp", 256'(bus.i_resp), 256'(1));
    tick();
    bus.i_read   = 1'b0;
    bus.d_read   = 1'b0;
    bus.mem_resp = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
